// File: rtl/fft_consts.sv
// Shared constants, types and helpers for the FFT frame sequencer.
package fft_consts;

  localparam int N_LOG2     = 10;
  localparam int DW         = 16;
  localparam int DW_COMPLEX = 2 * DW;

  // Complex sample, real part in the upper half of the packed word.
  typedef struct packed {
    logic [DW-1:0] r;
    logic [DW-1:0] i;
  } complex_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ZFILL  = 3'd2,
    START  = 3'd3,
    RUN    = 3'd4,
    UNLOAD = 3'd5
  } seq_state_t;

  // Mirror the address bits: sample k of a frame lives at bitrev(k).
  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] a);
    logic [N_LOG2-1:0] rev;
    rev = '0;
    for (int b = 0; b < N_LOG2; b++) begin
      rev[b] = a[N_LOG2-1-b];
    end
    return rev;
  endfunction

endpackage

// File: rtl/fft_out_buf.sv
// Two-entry FIFO feeding the spectrum output stream. The head entry drives
// out_data straight from a register, so data holds while the sink stalls.
module fft_out_buf #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occ
);

  logic [W-1:0] mem0;
  logic [W-1:0] mem1;
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  // The producer never offers data into a full buffer; the guard keeps the
  // storage consistent even if it did.
  assign push      = in_valid && (count != 2'd2);
  assign pop       = out_valid && out_ready;
  assign out_valid = (count != 2'd0);
  assign out_data  = rd_ptr ? mem1 : mem0;
  assign occ       = count;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem0   <= '0;
      mem1   <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr) mem1 <= in_data;
        else        mem0 <= in_data;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame controller around the 1024-point FFT core: loads a frame into bank 0
// in bit-reversed order, runs the core, then streams the spectrum out.
//
// Streams: a beat transfers on a rising edge where valid && ready are both
// high. A source holds valid and data steady until the transfer; a sink may
// raise or drop ready freely.
module fft_frame_sequencer
  import fft_consts::*;
#(
  parameter int DONE_TIMEOUT = 16384
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DW_COMPLEX-1:0] s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DW_COMPLEX-1:0] m_data,
  output logic                  m_last,
  output logic                  core_start,
  input  logic                  core_done,
  output logic                  hp_en,
  output logic                  hp_we,
  output logic                  hp_bank,
  output logic [N_LOG2-1:0]     hp_addr,
  output logic [DW_COMPLEX-1:0] hp_din,
  input  logic [DW_COMPLEX-1:0] hp_dout,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic                  timeout_err,
  output logic [2:0]            dbg_state
);

  localparam int N  = 1 << N_LOG2;
  localparam int TW = $clog2(DONE_TIMEOUT) + 1;
  localparam logic [N_LOG2:0] LAST_IDX = (N_LOG2 + 1)'(N - 1);
  localparam logic [TW-1:0]   TO_LAST  = TW'(DONE_TIMEOUT - 1);
  // The core leaves the spectrum in the bank its final pass wrote.
  localparam logic            RES_BANK = 1'(N_LOG2 % 2);

  seq_state_t        state;
  logic [N_LOG2:0]   k_cnt;
  logic [N_LOG2:0]   j_cnt;
  logic [TW-1:0]     run_cnt;
  logic              rd_pend;
  logic              rd_pend_last;
  logic              frame_done_r;
  logic              frame_err_r;
  logic              timeout_err_r;
  logic              s_fire;
  logic              m_pop;
  logic              rd_issue;
  logic [1:0]        buf_occ;
  logic [2:0]        room_cnt;
  logic              buf_valid;
  logic [DW_COMPLEX:0] buf_data;
  complex_t          zero_word;

  assign zero_word = '0;

  assign s_ready     = (state == LOAD);
  assign busy        = (state != IDLE);
  assign core_start  = (state == START);
  assign frame_done  = frame_done_r;
  assign frame_err   = frame_err_r;
  assign timeout_err = timeout_err_r;
  assign dbg_state   = state;

  assign s_fire  = s_ready && s_valid;
  assign m_pop   = buf_valid && m_ready;
  assign m_valid = buf_valid;
  assign m_data  = buf_data[DW_COMPLEX-1:0];
  assign m_last  = buf_valid && buf_data[DW_COMPLEX];

  // Entries the buffer will hold once this cycle's pop and the read already
  // in flight settle; a new read is only issued if that leaves a free slot,
  // which keeps the buffer from overflowing yet sustains one beat per cycle.
  assign room_cnt = {1'b0, buf_occ} - {2'b00, m_pop} + {2'b00, rd_pend};
  assign rd_issue = (state == UNLOAD) && !j_cnt[N_LOG2] && (room_cnt < 3'd2);

  // Host RAM port mux: writes during LOAD/ZFILL, reads during UNLOAD, idle
  // otherwise so the core owns the RAMs while it runs.
  always_comb begin
    hp_en   = 1'b0;
    hp_we   = 1'b0;
    hp_bank = 1'b0;
    hp_addr = '0;
    hp_din  = '0;
    case (state)
      LOAD: begin
        hp_en   = s_fire;
        hp_we   = s_fire;
        hp_addr = bitrev(k_cnt[N_LOG2-1:0]);
        hp_din  = s_data;
      end
      ZFILL: begin
        hp_en   = 1'b1;
        hp_we   = 1'b1;
        hp_addr = bitrev(k_cnt[N_LOG2-1:0]);
        hp_din  = zero_word;
      end
      UNLOAD: begin
        hp_en   = rd_issue;
        hp_bank = RES_BANK;
        hp_addr = j_cnt[N_LOG2-1:0];
      end
      default: ;
    endcase
  end

  // Frame sequencing FSM with its counters and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      k_cnt         <= '0;
      j_cnt         <= '0;
      run_cnt       <= '0;
      rd_pend       <= 1'b0;
      rd_pend_last  <= 1'b0;
      frame_done_r  <= 1'b0;
      frame_err_r   <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      rd_pend      <= rd_issue;
      rd_pend_last <= (j_cnt == LAST_IDX);
      case (state)
        IDLE: begin
          if (s_valid) begin
            state         <= LOAD;
            k_cnt         <= '0;
            frame_err_r   <= 1'b0;
            timeout_err_r <= 1'b0;
          end
        end
        LOAD: begin
          if (s_fire) begin
            k_cnt <= k_cnt + 1'b1;
            if (k_cnt == LAST_IDX) begin
              state <= START;
              if (!s_last) frame_err_r <= 1'b1;
            end else if (s_last) begin
              frame_err_r <= 1'b1;
              state       <= ZFILL;
            end
          end
        end
        ZFILL: begin
          k_cnt <= k_cnt + 1'b1;
          if (k_cnt == LAST_IDX) state <= START;
        end
        START: begin
          state   <= RUN;
          run_cnt <= '0;
        end
        RUN: begin
          if (core_done) begin
            state <= UNLOAD;
            j_cnt <= '0;
          end else if (run_cnt == TO_LAST) begin
            timeout_err_r <= 1'b1;
            state         <= IDLE;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        UNLOAD: begin
          if (rd_issue) j_cnt <= j_cnt + 1'b1;
          if (m_pop && buf_data[DW_COMPLEX]) begin
            frame_done_r <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fft_out_buf #(
    .W (DW_COMPLEX + 1)
  ) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_pend),
    .in_data   ({rd_pend_last, hp_dout}),
    .out_valid (buf_valid),
    .out_ready (m_ready),
    .out_data  (buf_data),
    .occ       (buf_occ)
  );

endmodule
